// File: rtl/conv_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_reader_if
// Description : Bus bundle for the CONV result-memory read-back engine.
//               Carries the control handshake (start/bank/busy/done), the
//               result-memory read port (crd/caddr_rd/cdata_rd/csel) and the
//               valid/ready output stream (o_valid/i_ready/o_data/o_addr/
//               o_last) plus the running checksum o_sum.
//               master : the reader engine's view
//               slave  : the host / memory / consumer view
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_result_reader_if;
  logic        i_start;
  logic [2:0]  i_bank;
  logic        o_busy;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic        o_valid;
  logic        i_ready;
  logic [19:0] o_data;
  logic [11:0] o_addr;
  logic        o_last;
  logic        o_done;
  logic [19:0] o_sum;

  modport master (
    input  i_start, i_bank, cdata_rd, i_ready,
    output o_busy, crd, caddr_rd, csel, o_valid, o_data, o_addr, o_last,
           o_done, o_sum
  );

  modport slave (
    output i_start, i_bank, cdata_rd, i_ready,
    input  o_busy, crd, caddr_rd, csel, o_valid, o_data, o_addr, o_last,
           o_done, o_sum
  );
endinterface
`default_nettype wire

// File: rtl/conv_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_reader
// Description : Scans one CONV result bank (addresses 0..N-1) through the
//               crd/caddr_rd/csel read port and streams the returned words
//               out through a first-word-fall-through buffer on a
//               valid/ready interface.
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous, active-low reset
//               bus    - conv_result_reader_if.master (start/bank/busy/done,
//                        read port, output stream, checksum)
// Parameters  : RD_LAT   - read data latency after crd is sampled (1 or 2)
//               FIFO_DEP - output buffer depth, power of 2, >= RD_LAT+1
// Macro       : READ_CHECKSUM_EN - when defined, o_sum accumulates the
//               streamed words (mod 2^20); otherwise o_sum is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_reader #(
  parameter int RD_LAT   = 1,
  parameter int FIFO_DEP = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  conv_result_reader_if.master  bus
);

  localparam int AW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
  localparam int CW = $clog2(FIFO_DEP) + 1;
  localparam logic [CW-1:0] c_fifo_dep = CW'(FIFO_DEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;

  logic [2:0]    r_bank;
  logic [11:0]   r_len_m1;
  logic [11:0]   r_addr;
  logic          r_crd;
  logic [11:0]   r_caddr;
  logic [RD_LAT:1] r_pv;
  logic [11:0]   r_pa [1:RD_LAT];
  // Words issued but not yet popped: in-flight reads plus buffered words.
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp, r_rp;
  logic [19:0]   r_mem_d [FIFO_DEP];
  logic [11:0]   r_mem_a [FIFO_DEP];

  logic          w_bank_ok;
  logic [11:0]   w_len_m1;
  logic          w_accept, w_issue, w_valid, w_pop, w_push;
  logic          w_busy, w_done;
  logic [CW-1:0] w_occ_nxt;
  logic [19:0]   w_head_d;
  logic [11:0]   w_head_a;

  always_comb begin
    w_bank_ok = 1'b1;
    w_len_m1  = 12'd0;
    case (bus.i_bank)
      3'b001, 3'b010: w_len_m1 = 12'd4095;
      3'b011, 3'b100: w_len_m1 = 12'd1023;
      3'b101:         w_len_m1 = 12'd2047;
      default:        w_bank_ok = 1'b0;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && bus.i_start && w_bank_ok;
  // Issuing only while total occupancy is below depth guarantees a slot for
  // every returning word, so backpressure can never drop data.
  assign w_issue   = (r_state == ST_ISSUE) && (r_occ < c_fifo_dep);
  assign w_valid   = (r_cnt != '0);
  assign w_pop     = w_valid && bus.i_ready;
  assign w_push    = r_pv[RD_LAT];
  assign w_occ_nxt = r_occ + CW'(w_issue) - CW'(w_pop);
  assign w_head_d  = r_mem_d[r_rp];
  assign w_head_a  = r_mem_a[r_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_busy = 1'b1;
        if (w_issue && (r_addr == r_len_m1)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        // Leave on the edge of the final pop so o_done follows it by one cycle.
        if (w_occ_nxt == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bank   <= '0;
      r_len_m1 <= '0;
      r_addr   <= '0;
      r_crd    <= 1'b0;
      r_caddr  <= '0;
      r_pv     <= '0;
      for (int i = 1; i <= RD_LAT; i++) r_pa[i] <= '0;
      r_occ    <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      for (int i = 0; i < FIFO_DEP; i++) begin
        r_mem_d[i] <= '0;
        r_mem_a[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_bank   <= bus.i_bank;
        r_len_m1 <= w_len_m1;
        r_addr   <= '0;
      end
      r_crd <= w_issue;
      if (w_issue) begin
        r_caddr <= r_addr;
        if (r_addr != r_len_m1) r_addr <= r_addr + 12'd1;
      end
      // Return pipeline: tracks which sampled read lands RD_LAT cycles later.
      r_pv[1] <= r_crd;
      r_pa[1] <= r_caddr;
      for (int i = 2; i <= RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
      r_occ <= w_occ_nxt;
      if (w_push) begin
        r_mem_d[r_wp] <= bus.cdata_rd;
        r_mem_a[r_wp] <= r_pa[RD_LAT];
        r_wp          <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef READ_CHECKSUM_EN
  logic [19:0] r_sum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_sum <= '0;
    else if (w_accept) r_sum <= '0;
    else if (w_pop)  r_sum <= r_sum + w_head_d;
  end
  assign bus.o_sum = r_sum;
`else
  assign bus.o_sum = 20'd0;
`endif

  assign bus.o_busy   = w_busy;
  assign bus.o_done   = w_done;
  assign bus.crd      = r_crd;
  assign bus.caddr_rd = r_caddr;
  assign bus.csel     = r_bank;
  assign bus.o_valid  = w_valid;
  assign bus.o_data   = w_valid ? w_head_d : 20'd0;
  assign bus.o_addr   = w_valid ? w_head_a : 12'd0;
  assign bus.o_last   = w_valid && (w_head_a == r_len_m1);

endmodule
`default_nettype wire

// File: tb/tb_conv_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_result_reader
// Description : Self-checking bench for conv_result_reader. A result-memory
//               model answers reads one cycle after crd is sampled; expected
//               words are queued at start and popped by a monitor on every
//               stream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_reader;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_result_reader_if bus();

  conv_result_reader #(.RD_LAT(1), .FIFO_DEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [19:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          data_mode = 0;
  int          ready_mode = 0;
  int          hs_cnt = 0;
  int          in_fl = 0;
  logic        pend_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_d;
  logic [11:0] prev_a;
  logic        prev_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mem_word(input logic [11:0] a);
    return (data_mode == 1) ? 20'hFFFFF : {8'h00, a};
  endfunction

  // Result memory: data for the sampled address is valid one cycle later.
  always @(posedge clk or negedge reset) begin
    if (!reset)       bus.cdata_rd <= 20'd0;
    else if (bus.crd) bus.cdata_rd <= mem_word(bus.caddr_rd);
  end

  // Consumer ready: 0 = always ready, 1 = toggling, 2 = held low.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ~bus.i_ready;
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshakes take effect at the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
      in_fl      = 0;
    end else begin
      if (bus.o_done || pend_done) chk("o_done_timing", bus.o_done, pend_done);
      pend_done = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", bus.o_valid, 1);
        chk("stall_data",  bus.o_data, prev_d);
        chk("stall_addr",  bus.o_addr, prev_a);
        chk("stall_last",  bus.o_last, prev_l);
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_d = bus.o_data;
      prev_a = bus.o_addr;
      prev_l = bus.o_last;
      if (bus.crd) begin
        in_fl++;
        chk("occupancy_le_depth", (in_fl <= 4), 1);
      end
      if (bus.o_valid && bus.i_ready) begin
        exp_t e;
        in_fl--;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got addr %0h data %0h expected no word", bus.o_addr, bus.o_data);
        end else begin
          e = sb.pop_front();
          chk("word_addr", bus.o_addr, e.addr);
          chk("word_data", bus.o_data, e.data);
          chk("word_last", bus.o_last, e.last);
        end
        hs_cnt++;
        pend_done = bus.o_last;
      end
    end
  end

  task automatic start(input logic [2:0] bank, input int n);
    exp_t e;
    for (int a = 0; a < n; a++) begin
      e.addr = a[11:0];
      e.data = mem_word(a[11:0]);
      e.last = (a == n - 1);
      sb.push_back(e);
    end
    hs_cnt = 0;
    bus.i_bank  = bank;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    @(negedge clk);
    while (!bus.o_done && k < limit) begin
      k++;
      @(negedge clk);
    end
    if (!bus.o_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no o_done expected o_done within %0d cycles", limit);
    end
    chk("busy_in_done", bus.o_busy, 0);
    chk("queue_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  bus.o_busy, 0);
    chk({tag, "_crd"},   bus.crd, 0);
    chk({tag, "_caddr"}, bus.caddr_rd, 0);
    chk({tag, "_csel"},  bus.csel, 0);
    chk({tag, "_valid"}, bus.o_valid, 0);
    chk({tag, "_data"},  bus.o_data, 0);
    chk({tag, "_addr"},  bus.o_addr, 0);
    chk({tag, "_last"},  bus.o_last, 0);
    chk({tag, "_done"},  bus.o_done, 0);
    chk({tag, "_sum"},   bus.o_sum, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int k;
    logic [19:0] exp_sum;
    bus.i_start = 1'b0;
    bus.i_bank  = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Bank 101, always ready: order, last, done and first-word latency.
    ready_mode = 0;
    start(3'b101, 2048);
    lat = 0;
    @(negedge clk);
    chk("busy_after_start", bus.o_busy, 1);
    chk("csel_101", bus.csel, 3'b101);
    while (!bus.o_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("first_valid_latency", lat, 3);
    wait_done(3000);
    chk("count_bank101", hs_cnt, 2048);

    // Bank 011, toggling ready.
    ready_mode = 1;
    start(3'b011, 1024);
    wait_done(5000);
    chk("count_bank011", hs_cnt, 1024);

    // Bank 001, consumer stalled for 50 cycles after start.
    ready_mode = 2;
    @(posedge clk);
    #1;
    start(3'b001, 4096);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.crd) n++;
    end
    chk("reads_while_stalled", n, 4);
    chk("stalled_valid", bus.o_valid, 1);
    chk("stalled_head_addr", bus.o_addr, 0);
    // Start with another bank mid-frame: ignored.
    @(posedge clk);
    #1;
    bus.i_bank  = 3'b010;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("csel_held", bus.csel, 3'b001);
    chk("busy_held", bus.o_busy, 1);
    chk("no_restart_head", bus.o_addr, 0);
    ready_mode = 0;
    k = 0;
    @(negedge clk);
    while (!bus.crd && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("resume_crd", bus.crd, 1);
    chk("resume_addr", bus.caddr_rd, 4);
    wait_done(6000);
    chk("count_bank001", hs_cnt, 4096);

    // Invalid bank 111 from idle: ignored.
    bus.i_bank  = 3'b111;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("bad_bank_busy", bus.o_busy, 0);
    chk("bad_bank_crd", bus.crd, 0);
    chk("bad_bank_csel", bus.csel, 3'b001);
    @(posedge clk);
    #1;

    // Reset at word 500 of bank 010, then a clean restart.
    start(3'b010, 4096);
    k = 0;
    while (hs_cnt < 500 && k < 2000) begin
      k++;
      @(negedge clk);
    end
    chk("reached_word_500", (hs_cnt >= 500), 1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    start(3'b010, 4096);
    wait_done(6000);
    chk("count_bank010", hs_cnt, 4096);

    // Bank 100 with all-ones words: checksum.
    data_mode = 1;
    start(3'b100, 1024);
    wait_done(3000);
    chk("count_bank100", hs_cnt, 1024);
`ifdef READ_CHECKSUM_EN
    exp_sum = 20'hFFC00;
`else
    exp_sum = 20'h00000;
`endif
    chk("checksum", bus.o_sum, exp_sum);
    repeat (3) @(negedge clk);
    chk("checksum_hold", bus.o_sum, exp_sum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
